cci_rsp_engine: RTL and testbench
=================================

CCI_RSP_ENGINE -- requirements
Module: cci_rsp_engine

Interface
REQ-001 Parameters: LATENCY, default 8, request-to-response delay in cycles (legal range 1..255); DEPTH, default 8, entries per request queue (power of 2); AF_MARGIN, default 2, free entries remaining at almostfull assertion; INIT_DELAY, default 16, cycles from reset release to lp_initdone; MEM_LINES, default 16, backing-store lines (power of 2).
REQ-002 Ports, in order:
  clk  in  1  sole clock, rising edge.
  sys_reset_n  in  1  asynchronous, active-low reset.
  lp_initdone  out  1  link ready.
  tx_c0_header  in  `CCI_TX_HDR_WIDTH  read request header.
  tx_c0_rdvalid  in  1  read request strobe.
  tx_c0_almostfull  out  1  read queue backpressure.
  tx_c1_header  in  `CCI_TX_HDR_WIDTH  write request header.
  tx_c1_data  in  `CCI_DATA_WIDTH  write data.
  tx_c1_wrvalid  in  1  write request strobe.
  tx_c1_almostfull  out  1  write queue backpressure.
  rx_c0_header  out  `ASE_CCI_RX_HDR_WIDTH  read response header.
  rx_c0_data  out  `CCI_DATA_WIDTH  read response data.
  rx_c0_rdvalid  out  1  read response strobe.
  rx_c0_wrvalid  out  1  always 0.
  rx_c1_header  out  `ASE_CCI_RX_HDR_WIDTH  write response header.
  rx_c1_wrvalid  out  1  write/fence response strobe.
  err_flags  out  4  sticky errors: [0] request before initdone, [1] read overflow, [2] write overflow, [3] unknown type.

Function
REQ-003 Init counter starts at reset release and counts to INIT_DELAY; lp_initdone is set on the cycle the counter reaches INIT_DELAY and stays 1 until reset.
REQ-004 A free-running 16-bit cycle counter wraps modulo 2^16; every age comparison uses modulo-2^16 subtraction.
REQ-005 A tx_c0_rdvalid with type `ASE_TX0_RDLINE, `ASE_TX0_RDLINE_S, `ASE_TX0_RDLINE_I or `ASE_TX0_RDLINE_O pushes {mdata, line index = addr[log2(MEM_LINES)-1:0], stamp} into the read queue. Addr is header[45:14]; mdata is `TX_MDATA_BITRANGE.
REQ-006 A tx_c1_wrvalid with type `ASE_TX1_WRLINE or `ASE_TX1_WRTHRU pushes {mdata, index, data, stamp} into the write queue; type `ASE_TX1_WRFENCE pushes a fence entry carrying mdata only.
REQ-007 Any other type code is dropped and sets err_flags[3].
REQ-008 Any request with lp_initdone=0 is dropped and sets err_flags[0].
REQ-009 Each queue pops its head in the cycle where (cycle - stamp) >= LATENCY. Heads pop in order: a younger entry never pops before an older one.
REQ-010 Read pop: next cycle, rx_c0_rdvalid=1 for exactly 1 cycle, rx_c0_header[`RX_MDATA_BITRANGE]=mdata, all other header bits 0, rx_c0_data=mem[index] as sampled at the pop cycle.
REQ-011 Write pop: mem[index]<=data in the pop cycle; the next cycle drives rx_c1_wrvalid=1 with mdata.
REQ-012 Fence pop: no memory update; response identical to a write response.
REQ-013 Read and write pops in the same cycle to the same index: the read returns the pre-write data.
REQ-014 tx_cN_almostfull = (count >= DEPTH-AF_MARGIN), registered.
REQ-015 A push while count==DEPTH is dropped and sets err_flags[1] (read queue) or err_flags[2] (write queue).
REQ-016 Push and pop in the same cycle: count is unchanged and both take effect.
REQ-017 Both queues operate independently; both rx strobes may be 1 in the same cycle.
REQ-018 With no pending response, rx headers and data hold 0.

Reset
REQ-019 On sys_reset_n=0, immediately, without a clock edge: all outputs 0, queues empty, counters 0, err_flags 0, memory cleared to 0.
REQ-020 Requests pending at a reset mid-operation are discarded and never produce a response.

Structure
REQ-021 A shared package cci_rsp_pkg holds the request-type codes, the queue-entry struct typedefs and the err_flags bit indices; header macros come from the existing CCI defines.
REQ-022 One sub-module, cci_rsp_fifo (parameterised width/depth, count, almostfull, overflow), is instantiated twice.

Verification
REQ-023 Release reset; lp_initdone rises exactly 16 cycles later; a read sent at cycle 5 sets err_flags[0] and produces no response.
REQ-024 WrLine addr 0x3, mdata 0x011, data all-0xA5, then RdLine_S addr 0x3, mdata 0x022 on the next cycle: rx_c1_wrvalid carries mdata 0x011, then rx_c0_rdvalid carries mdata 0x022 and data all-0xA5, each 9 cycles after its request.
REQ-025 Send 8 back-to-back reads: almostfull asserts after the 6th; a 9th read in the same window sets err_flags[1]; exactly 8 responses return, in order of mdata.
REQ-026 Issue a WrFence mdata 0x3FF: rx_c1_wrvalid with mdata 0x3FF after LATENCY+1 cycles; memory unchanged.
REQ-027 Request type 0xF on c1: dropped; err_flags[3]=1; no response.
REQ-028 Assert reset with 4 reads pending, release after 3 cycles: no rx strobes occur and a read of any index returns 0 after re-init.

Source files
------------

// File: rtl/cci_rsp_pkg.sv
// Shared request-type codes, header field positions and queue-entry layouts
// for the CCI response engine.
package cci_rsp_pkg;

    // Header geometry of the CCI link: TX type in [55:52], address in [45:14], mdata in [13:0]
    localparam int CCI_TX_HDR_WIDTH     = 61;
    localparam int CCI_DATA_WIDTH       = 512;
    localparam int ASE_CCI_RX_HDR_WIDTH = 18;
    localparam int TX_TYPE_LSB          = 52;
    localparam int TX_TYPE_W            = 4;
    localparam int TX_ADDR_LSB          = 14;
    localparam int MDATA_W              = 14;
    localparam int IDX_MAX_W            = 8;
    localparam int STAMP_W              = 16;

    typedef enum logic [TX_TYPE_W-1:0] {
        ASE_TX0_RDLINE_S = 4'h4,
        ASE_TX0_RDLINE_I = 4'h6,
        ASE_TX0_RDLINE_O = 4'h7,
        ASE_TX0_RDLINE   = 4'hC
    } tx0_type_e;

    typedef enum logic [TX_TYPE_W-1:0] {
        ASE_TX1_WRTHRU  = 4'h1,
        ASE_TX1_WRLINE  = 4'h2,
        ASE_TX1_WRFENCE = 4'h5
    } tx1_type_e;

    localparam int ERR_NOT_INIT = 0;
    localparam int ERR_RD_OVF   = 1;
    localparam int ERR_WR_OVF   = 2;
    localparam int ERR_BAD_TYPE = 3;

    typedef struct packed {
        logic [MDATA_W-1:0]   mdata;
        logic [IDX_MAX_W-1:0] idx;
        logic [STAMP_W-1:0]   stamp;
    } rd_entry_t;

    typedef struct packed {
        logic                      fence;
        logic [MDATA_W-1:0]        mdata;
        logic [IDX_MAX_W-1:0]      idx;
        logic [CCI_DATA_WIDTH-1:0] data;
        logic [STAMP_W-1:0]        stamp;
    } wr_entry_t;

    function automatic logic is_rd_type(input logic [TX_TYPE_W-1:0] t);
        return t inside {ASE_TX0_RDLINE, ASE_TX0_RDLINE_S, ASE_TX0_RDLINE_I, ASE_TX0_RDLINE_O};
    endfunction

    function automatic logic is_wr_type(input logic [TX_TYPE_W-1:0] t);
        return t inside {ASE_TX1_WRLINE, ASE_TX1_WRTHRU, ASE_TX1_WRFENCE};
    endfunction

endpackage

// File: rtl/cci_rsp_engine_if.sv
// CCI request/response bus between an AFU (master) and the response engine (slave).
interface cci_rsp_engine_if;
    import cci_rsp_pkg::*;

    logic                            lp_initdone;
    logic [CCI_TX_HDR_WIDTH-1:0]     tx_c0_header;
    logic                            tx_c0_rdvalid;
    logic                            tx_c0_almostfull;
    logic [CCI_TX_HDR_WIDTH-1:0]     tx_c1_header;
    logic [CCI_DATA_WIDTH-1:0]       tx_c1_data;
    logic                            tx_c1_wrvalid;
    logic                            tx_c1_almostfull;
    logic [ASE_CCI_RX_HDR_WIDTH-1:0] rx_c0_header;
    logic [CCI_DATA_WIDTH-1:0]       rx_c0_data;
    logic                            rx_c0_rdvalid;
    logic                            rx_c0_wrvalid;
    logic [ASE_CCI_RX_HDR_WIDTH-1:0] rx_c1_header;
    logic                            rx_c1_wrvalid;

    modport master (
        input  lp_initdone,
        output tx_c0_header, tx_c0_rdvalid,
        input  tx_c0_almostfull,
        output tx_c1_header, tx_c1_data, tx_c1_wrvalid,
        input  tx_c1_almostfull,
        input  rx_c0_header, rx_c0_data, rx_c0_rdvalid, rx_c0_wrvalid,
        input  rx_c1_header, rx_c1_wrvalid
    );

    modport slave (
        output lp_initdone,
        input  tx_c0_header, tx_c0_rdvalid,
        output tx_c0_almostfull,
        input  tx_c1_header, tx_c1_data, tx_c1_wrvalid,
        output tx_c1_almostfull,
        output rx_c0_header, rx_c0_data, rx_c0_rdvalid, rx_c0_wrvalid,
        output rx_c1_header, rx_c1_wrvalid
    );

endinterface

// File: rtl/cci_rsp_fifo.sv
// Request queue: circular buffer with occupancy count, registered almost-full
// flag and an overflow pulse for pushes that arrive while full.
module cci_rsp_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almostfull,
    output logic                     overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] AF_CNT   = (PTR_W+1)'(DEPTH - AF_MARGIN);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   cnt, cnt_next;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push && (cnt != FULL_CNT);
        do_pop   = pop && (cnt != '0);
        cnt_next = cnt;
        if (do_push && !do_pop)
            cnt_next = cnt + 1'b1;
        else if (!do_push && do_pop)
            cnt_next = cnt - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            almostfull <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt        <= cnt_next;
            // Registered from the next count so the flag lines up with count itself
            almostfull <= (cnt_next >= AF_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= din;
    end

    assign dout     = store[rd_ptr];
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign overflow = push && (cnt == FULL_CNT);

endmodule

// File: rtl/cci_rsp_engine.sv
// CCI link responder: queues read/write/fence requests, answers each after a
// fixed latency from a small cleared-on-reset backing store.
module cci_rsp_engine
    import cci_rsp_pkg::*;
#(
    parameter int LATENCY    = 8,
    parameter int DEPTH      = 8,
    parameter int AF_MARGIN  = 2,
    parameter int INIT_DELAY = 16,
    parameter int MEM_LINES  = 16
) (
    input  logic             clk,
    input  logic             sys_reset_n,
    cci_rsp_engine_if.slave  bus,
    output logic [3:0]       err_flags
);
    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [STAMP_W-1:0] LAT      = STAMP_W'(LATENCY);
    localparam logic [15:0]        INIT_CNT = 16'(INIT_DELAY);

    logic [STAMP_W-1:0]  cycle_p0;
    logic [15:0]         init_cnt;
    logic                initdone;
    logic [TX_TYPE_W-1:0] c0_type, c1_type;
    logic                rd_known, wr_known, rd_push, wr_push;
    rd_entry_t           rd_in, rd_head;
    wr_entry_t           wr_in, wr_head;
    logic                rd_empty, wr_empty, rd_af, wr_af, rd_ovf, wr_ovf;
    logic [CNT_W-1:0]    rd_count, wr_count;
    logic [STAMP_W-1:0]  rd_age, wr_age;
    logic                rd_pop, wr_pop;

    logic [CCI_DATA_WIDTH-1:0]       mem [MEM_LINES];
    logic                            c0_vld_p1, c1_vld_p1;
    logic [ASE_CCI_RX_HDR_WIDTH-1:0] c0_hdr_p1, c1_hdr_p1;
    logic [CCI_DATA_WIDTH-1:0]       c0_data_p1;

    always_ff @(posedge clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            cycle_p0 <= '0;
            init_cnt <= '0;
            initdone <= 1'b0;
        end else begin
            cycle_p0 <= cycle_p0 + 1'b1;
            if (!initdone) begin
                init_cnt <= init_cnt + 16'd1;
                if (init_cnt + 16'd1 == INIT_CNT) initdone <= 1'b1;
            end
        end
    end

    // Stage p0: decode requests into queue entries stamped with the current cycle
    always_comb begin
        c0_type  = bus.tx_c0_header[TX_TYPE_LSB +: TX_TYPE_W];
        c1_type  = bus.tx_c1_header[TX_TYPE_LSB +: TX_TYPE_W];
        rd_known = is_rd_type(c0_type);
        wr_known = is_wr_type(c1_type);
        rd_push  = bus.tx_c0_rdvalid && initdone && rd_known;
        wr_push  = bus.tx_c1_wrvalid && initdone && wr_known;

        rd_in                = '0;
        rd_in.mdata          = bus.tx_c0_header[MDATA_W-1:0];
        rd_in.idx[IDX_W-1:0] = bus.tx_c0_header[TX_ADDR_LSB +: IDX_W];
        rd_in.stamp          = cycle_p0;

        wr_in       = '0;
        wr_in.fence = (c1_type == ASE_TX1_WRFENCE);
        wr_in.mdata = bus.tx_c1_header[MDATA_W-1:0];
        wr_in.stamp = cycle_p0;
        if (!wr_in.fence) begin
            wr_in.idx[IDX_W-1:0] = bus.tx_c1_header[TX_ADDR_LSB +: IDX_W];
            wr_in.data           = bus.tx_c1_data;
        end
    end

    cci_rsp_fifo #(.WIDTH($bits(rd_entry_t)), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)) u_rd_fifo (
        .clk(clk), .rst_n(sys_reset_n), .push(rd_push), .din(rd_in), .pop(rd_pop),
        .dout(rd_head), .empty(rd_empty), .count(rd_count), .almostfull(rd_af), .overflow(rd_ovf)
    );

    cci_rsp_fifo #(.WIDTH($bits(wr_entry_t)), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)) u_wr_fifo (
        .clk(clk), .rst_n(sys_reset_n), .push(wr_push), .din(wr_in), .pop(wr_pop),
        .dout(wr_head), .empty(wr_empty), .count(wr_count), .almostfull(wr_af), .overflow(wr_ovf)
    );

    // Ages wrap with the 16-bit cycle counter, so the subtraction stays modulo 2^16
    always_comb begin
        rd_age = cycle_p0 - rd_head.stamp;
        wr_age = cycle_p0 - wr_head.stamp;
        rd_pop = !rd_empty && (rd_age >= LAT);
        wr_pop = !wr_empty && (wr_age >= LAT);
    end

    // Stage p1: memory update and registered responses; reads see pre-write data
    always_ff @(posedge clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            for (int i = 0; i < MEM_LINES; i++) mem[i] <= '0;
            c0_vld_p1  <= 1'b0;
            c0_hdr_p1  <= '0;
            c0_data_p1 <= '0;
            c1_vld_p1  <= 1'b0;
            c1_hdr_p1  <= '0;
            err_flags  <= '0;
        end else begin
            if (wr_pop && !wr_head.fence) mem[wr_head.idx[IDX_W-1:0]] <= wr_head.data;
            c0_vld_p1  <= rd_pop;
            c0_hdr_p1  <= rd_pop ? ASE_CCI_RX_HDR_WIDTH'(rd_head.mdata) : '0;
            c0_data_p1 <= rd_pop ? mem[rd_head.idx[IDX_W-1:0]] : '0;
            c1_vld_p1  <= wr_pop;
            c1_hdr_p1  <= wr_pop ? ASE_CCI_RX_HDR_WIDTH'(wr_head.mdata) : '0;
            if ((bus.tx_c0_rdvalid || bus.tx_c1_wrvalid) && !initdone)
                err_flags[ERR_NOT_INIT] <= 1'b1;
            if (rd_ovf) err_flags[ERR_RD_OVF] <= 1'b1;
            if (wr_ovf) err_flags[ERR_WR_OVF] <= 1'b1;
            if (initdone && ((bus.tx_c0_rdvalid && !rd_known) || (bus.tx_c1_wrvalid && !wr_known)))
                err_flags[ERR_BAD_TYPE] <= 1'b1;
        end
    end

    assign bus.lp_initdone      = initdone;
    assign bus.tx_c0_almostfull = rd_af;
    assign bus.tx_c1_almostfull = wr_af;
    assign bus.rx_c0_header     = c0_hdr_p1;
    assign bus.rx_c0_data       = c0_data_p1;
    assign bus.rx_c0_rdvalid    = c0_vld_p1;
    assign bus.rx_c0_wrvalid    = 1'b0;
    assign bus.rx_c1_header     = c1_hdr_p1;
    assign bus.rx_c1_wrvalid    = c1_vld_p1;

    logic unused_ok;
    assign unused_ok = ^{bus.tx_c0_header, bus.tx_c1_header, rd_head.idx, wr_head.idx, rd_count, wr_count};

endmodule

// File: tb/tb_cci_rsp_engine.sv
// Directed bench for cci_rsp_engine: a queue/array model of the response rules
// is compared every cycle, plus hand-computed expectations for each scenario.
module tb_cci_rsp_engine;
    import cci_rsp_pkg::*;

    localparam int LAT = 8, DEPTH = 8, AF_TH = 6, INIT = 16, LINES = 16;

    logic       clk = 1'b0;
    logic       sys_reset_n;
    logic [3:0] err_flags;

    cci_rsp_engine_if bus();

    cci_rsp_engine #(.LATENCY(LAT), .DEPTH(DEPTH), .AF_MARGIN(2), .INIT_DELAY(INIT), .MEM_LINES(LINES)) dut (
        .clk(clk), .sys_reset_n(sys_reset_n), .bus(bus), .err_flags(err_flags)
    );

    always #5 clk = ~clk;

    typedef struct { int mdata; int idx; int due; } rd_t;
    typedef struct { int mdata; int idx; logic [511:0] data; bit fence; int due; } wr_t;

    int checks = 0, errors = 0;
    int now;
    int c0_strobes = 0, c1_strobes = 0;
    rd_t rdq[$];
    wr_t wrq[$];
    logic [511:0] mem_m [LINES];
    logic [3:0]   err_m;

    function automatic void chk(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endfunction

    // Cycles since reset release; equals the DUT's stamp clock for this run
    always @(posedge clk or negedge sys_reset_n) begin
        if (!sys_reset_n) now <= 0;
        else              now <= now + 1;
    end

    // Every accepted request answers LAT+1 cycles later; reads are served before
    // same-cycle writes land in memory.
    always @(negedge clk) begin : cmp
        logic        ev;
        logic [17:0] eh;
        logic [511:0] ed;
        if (sys_reset_n === 1'b1) begin
            ev = 1'b0; eh = '0; ed = '0;
            if (rdq.size() > 0 && rdq[0].due <= now) begin
                ev = 1'b1; eh = 18'(rdq[0].mdata); ed = mem_m[rdq[0].idx];
                void'(rdq.pop_front());
            end
            chk("c0_vld", bus.rx_c0_rdvalid, ev);
            chk("c0_hdr", bus.rx_c0_header, eh);
            chk("c0_data", bus.rx_c0_data, ed);
            ev = 1'b0; eh = '0;
            if (wrq.size() > 0 && wrq[0].due <= now) begin
                ev = 1'b1; eh = 18'(wrq[0].mdata);
                if (!wrq[0].fence) mem_m[wrq[0].idx] = wrq[0].data;
                void'(wrq.pop_front());
            end
            chk("c1_vld", bus.rx_c1_wrvalid, ev);
            chk("c1_hdr", bus.rx_c1_header, eh);
            chk("c0_wrvalid", bus.rx_c0_wrvalid, 1'b0);
            chk("c0_af", bus.tx_c0_almostfull, rdq.size() >= AF_TH);
            chk("c1_af", bus.tx_c1_almostfull, wrq.size() >= AF_TH);
            chk("err_flags", err_flags, err_m);
            chk("initdone", bus.lp_initdone, now >= INIT);
            if (bus.rx_c0_rdvalid === 1'b1) c0_strobes++;
            if (bus.rx_c1_wrvalid === 1'b1) c1_strobes++;
        end
    end

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic wait_until(input int target);
        int g = 0;
        while (now < target && g < 2000) begin step(); g++; end
        chk("wait_bound", now, target);
    endtask

    task automatic model_clear();
        rdq.delete(); wrq.delete(); err_m = '0;
        for (int i = 0; i < LINES; i++) mem_m[i] = '0;
    endtask

    task automatic drive_rd(input logic [3:0] typ, input int addr, input int mdata);
        logic [60:0] h;
        rd_t e;
        h = '0; h[55:52] = typ; h[45:14] = 32'(addr); h[13:0] = 14'(mdata);
        bus.tx_c0_header = h; bus.tx_c0_rdvalid = 1'b1;
        if (now < INIT) err_m[0] = 1'b1;
        else if (!(typ inside {ASE_TX0_RDLINE, ASE_TX0_RDLINE_S, ASE_TX0_RDLINE_I, ASE_TX0_RDLINE_O})) err_m[3] = 1'b1;
        else if (rdq.size() >= DEPTH) err_m[1] = 1'b1;
        else begin
            e.mdata = mdata; e.idx = addr % LINES; e.due = now + LAT + 1;
            rdq.push_back(e);
        end
    endtask

    task automatic drive_wr(input logic [3:0] typ, input int addr, input int mdata, input logic [511:0] d);
        logic [60:0] h;
        wr_t e;
        h = '0; h[55:52] = typ; h[45:14] = 32'(addr); h[13:0] = 14'(mdata);
        bus.tx_c1_header = h; bus.tx_c1_data = d; bus.tx_c1_wrvalid = 1'b1;
        if (now < INIT) err_m[0] = 1'b1;
        else if (!(typ inside {ASE_TX1_WRLINE, ASE_TX1_WRTHRU, ASE_TX1_WRFENCE})) err_m[3] = 1'b1;
        else if (wrq.size() >= DEPTH) err_m[2] = 1'b1;
        else begin
            e.mdata = mdata; e.idx = addr % LINES; e.data = d;
            e.fence = (typ == ASE_TX1_WRFENCE); e.due = now + LAT + 1;
            wrq.push_back(e);
        end
    endtask

    task automatic idle();
        bus.tx_c0_rdvalid = 1'b0; bus.tx_c0_header = '0;
        bus.tx_c1_wrvalid = 1'b0; bus.tx_c1_header = '0; bus.tx_c1_data = '0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, s0, s1;
        idle();
        model_clear();
        sys_reset_n = 1'b1;
        #2 sys_reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_initdone", bus.lp_initdone, 1'b0);
        chk("rst_err", err_flags, 4'h0);
        chk("rst_c0_vld", bus.rx_c0_rdvalid, 1'b0);
        chk("rst_c0_data", bus.rx_c0_data, '0);
        sys_reset_n = 1'b1;

        // Early read is dropped and flagged; link comes up 16 cycles after release
        wait_until(5);
        drive_rd(ASE_TX0_RDLINE, 1, 'h005);
        step(); idle();
        s0 = 0;
        while (!bus.lp_initdone && s0 < 40) begin step(); s0++; end
        chk("init_latency", now, 16);
        chk("err_not_init", err_flags, 4'b0001);

        // Write then read of line 3 on the next cycle
        step(); t0 = now;
        drive_wr(ASE_TX1_WRLINE, 3, 'h011, {64{8'hA5}});
        step(); bus.tx_c1_wrvalid = 1'b0;
        drive_rd(ASE_TX0_RDLINE_S, 3, 'h022);
        step(); idle();
        wait_until(t0 + 9);
        chk("wr_rsp_vld", bus.rx_c1_wrvalid, 1'b1);
        chk("wr_rsp_mdata", bus.rx_c1_header, 18'h011);
        step();
        chk("rd_rsp_vld", bus.rx_c0_rdvalid, 1'b1);
        chk("rd_rsp_mdata", bus.rx_c0_header, 18'h022);
        chk("rd_rsp_data", bus.rx_c0_data, {64{8'hA5}});

        // Same-cycle read and write of line 5: read returns the old contents
        step(); t0 = now;
        drive_wr(ASE_TX1_WRTHRU, 5, 'h033, {64{8'h5A}});
        drive_rd(ASE_TX0_RDLINE_I, 5, 'h044);
        step(); idle();
        wait_until(t0 + 9);
        chk("same_idx_both_vld", {bus.rx_c0_rdvalid, bus.rx_c1_wrvalid}, 2'b11);
        chk("same_idx_old_data", bus.rx_c0_data, '0);
        step(); t0 = now;
        drive_rd(ASE_TX0_RDLINE_O, 5, 'h055);
        step(); idle();
        wait_until(t0 + 9);
        chk("same_idx_new_data", bus.rx_c0_data, {64{8'h5A}});

        // Eight back-to-back reads fill the queue; a ninth overflows
        wait_until(now + 4);
        t0 = now; s0 = c0_strobes;
        for (int i = 0; i < 9; i++) begin
            chk("rd_af_fill", bus.tx_c0_almostfull, i >= 6);
            drive_rd(ASE_TX0_RDLINE, i, 'h100 + i);
            step();
        end
        idle();
        chk("err_rd_ovf", err_flags, 4'b0011);
        wait_until(t0 + 25);
        chk("rd_burst_count", c0_strobes - s0, 8);

        // Fence answers like a write and leaves memory alone
        t0 = now;
        drive_wr(ASE_TX1_WRFENCE, 3, 'h3FF, {512{1'b1}});
        step(); idle();
        wait_until(t0 + 9);
        chk("fence_vld", bus.rx_c1_wrvalid, 1'b1);
        chk("fence_mdata", bus.rx_c1_header, 18'h3FF);
        step(); t0 = now;
        drive_rd(ASE_TX0_RDLINE, 3, 'h066);
        step(); idle();
        wait_until(t0 + 9);
        chk("fence_mem_kept", bus.rx_c0_data, {64{8'hA5}});

        // Unknown type on c1 is dropped
        step(); t0 = now; s1 = c1_strobes;
        drive_wr(4'hF, 2, 'h077, {64{8'h11}});
        step(); idle();
        wait_until(t0 + 14);
        chk("err_bad_type", err_flags, 4'b1011);
        chk("bad_type_no_rsp", c1_strobes - s1, 0);

        // Reset with four reads in flight
        for (int i = 0; i < 4; i++) begin
            drive_rd(ASE_TX0_RDLINE, i, 'h200 + i);
            step();
        end
        idle(); step();
        sys_reset_n = 1'b0;
        model_clear();
        #1;
        chk("mid_rst_initdone", bus.lp_initdone, 1'b0);
        chk("mid_rst_err", err_flags, 4'h0);
        chk("mid_rst_c0_vld", bus.rx_c0_rdvalid, 1'b0);
        chk("mid_rst_c0_af", bus.tx_c0_almostfull, 1'b0);
        s0 = c0_strobes;
        repeat (3) step();
        sys_reset_n = 1'b1;
        wait_until(INIT);
        chk("reinit_done", bus.lp_initdone, 1'b1);
        chk("no_stale_rsp", c0_strobes - s0, 0);
        t0 = now;
        drive_rd(ASE_TX0_RDLINE, 3, 'h088);
        step(); idle();
        wait_until(t0 + 9);
        chk("post_rst_vld", bus.rx_c0_rdvalid, 1'b1);
        chk("post_rst_data", bus.rx_c0_data, '0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
